// File: rtl/inq_frame_store.sv
// Packs a raster stream of pixel pairs into row-pair words and serves reads.
// A frame is visible one cycle after its last beat. The stream stalls (pix_ready=0) until frame_done.
module inq_frame_store #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_eol,
    output logic              pix_ready,
    input  logic [ADDR_W-1:0] inq_addr,
    input  logic              inq_update,
    output logic [31:0]       MB_flat,
    output logic              MB_ready,
    output logic              data_ready,
    input  logic              frame_done,
    output logic              frame_err
);

    localparam int STRIDE = IMG_W / 2;
    localparam int DEPTH  = STRIDE * (IMG_H / 2);
    localparam int IW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int MW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        FILL     = 2'd1,
        READY    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [YW-1:0]   y_q, y_d;
    logic [MW-1:0]   base_q, base_d;
    logic            mb_ready_q, mb_ready_d;
    logic            frame_err_q, frame_err_d;

    logic [31:0]     mem     [DEPTH];
    logic [15:0]     linebuf [STRIDE];

    logic            beat_acc, take, eol_bad, last_pair, last_row;
    logic            lb_we, mem_we, rd_hit;
    logic [IW-1:0]   cur_i;
    logic [YW-1:0]   cur_y;
    logic [MW-1:0]   cur_base, wr_addr;

    assign pix_ready = !reset && (state_q != READY);
    assign beat_acc  = pix_valid && pix_ready;
    // Beats only count once a start of frame has been seen; stray beats are swallowed.
    assign take      = beat_acc && ((state_q == FILL) || pix_sof);

    // A start of frame always restarts the position at x=0, y=0.
    assign cur_i     = pix_sof ? '0 : i_q;
    assign cur_y     = pix_sof ? '0 : y_q;
    assign cur_base  = pix_sof ? '0 : base_q;

    assign last_pair = (cur_i == IW'(STRIDE - 1));
    assign last_row  = (cur_y == YW'(IMG_H - 1));
    assign eol_bad   = (pix_eol != last_pair);

    assign lb_we     = take && !eol_bad && !cur_y[0];
    assign mem_we    = take && !eol_bad && cur_y[0];
    assign wr_addr   = cur_base + MW'(cur_i);

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        y_d         = y_q;
        base_d      = base_q;
        mb_ready_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            WAIT_SOF, FILL: begin
                if (take) begin
                    frame_err_d = eol_bad || ((state_q == FILL) && pix_sof);
                    if (eol_bad) begin
                        state_d = WAIT_SOF;
                        i_d     = '0;
                        y_d     = '0;
                        base_d  = '0;
                    end else begin
                        state_d = FILL;
                        y_d     = cur_y;
                        base_d  = cur_base;
                        if (last_pair) begin
                            i_d = '0;
                            if (last_row) begin
                                state_d    = READY;
                                y_d        = '0;
                                base_d     = '0;
                                mb_ready_d = 1'b1;
                            end else begin
                                y_d = cur_y + 1'b1;
                                if (cur_y[0]) begin
                                    base_d = cur_base + MW'(STRIDE);
                                end
                            end
                        end else begin
                            i_d = cur_i + 1'b1;
                        end
                    end
                end
            end
            READY: begin
                if (frame_done) begin
                    state_d = WAIT_SOF;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_SOF;
            i_q         <= '0;
            y_q         <= '0;
            base_q      <= '0;
            mb_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            y_q         <= y_d;
            base_q      <= base_d;
            mb_ready_q  <= mb_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage is deliberately left unreset; a complete frame overwrites every word.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[cur_i] <= pix_data;
        end
        if (mem_we) begin
            mem[wr_addr] <= {pix_data, linebuf[cur_i]};
        end
    end

    assign rd_hit     = inq_update && ({1'b0, inq_addr} < (ADDR_W + 1)'(DEPTH));
    assign MB_flat    = rd_hit ? mem[inq_addr[MW-1:0]] : 32'h0;
    assign MB_ready   = mb_ready_q;
    assign data_ready = (state_q == READY);
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_inq_frame_store.sv
// Directed bench for inq_frame_store at 8x4 pixels, p(x,y) = off + y*16 + x.
module tb_inq_frame_store;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   pix_data;
    logic          pix_valid, pix_sof, pix_eol, pix_ready;
    logic [AW-1:0] inq_addr;
    logic          inq_update;
    logic [31:0]   MB_flat;
    logic          MB_ready, data_ready, frame_done, frame_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inq_frame_store #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_ready  (pix_ready),
        .inq_addr   (inq_addr),
        .inq_update (inq_update),
        .MB_flat    (MB_flat),
        .MB_ready   (MB_ready),
        .data_ready (data_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int x, input int y, input logic [7:0] off);
        return off + 8'(y * 16 + x);
    endfunction

    task automatic beat(input int i, input int y, input logic [7:0] off,
                        input logic sof, input logic eol);
        pix_data  = {pv(2 * i + 1, y, off), pv(2 * i, y, off)};
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_eol   = eol;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eol   = 1'b0;
    endtask

    task automatic rd(input string tag, input int addr, input logic upd, input logic [31:0] exp);
        inq_addr   = AW'(addr);
        inq_update = upd;
        #1;
        check(tag, MB_flat, exp);
        inq_update = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] off, input logic exp_err);
        for (int y = 0; y < H; y++) begin
            for (int i = 0; i < W / 2; i++) begin
                beat(i, y, off, (y == 0 && i == 0), (i == W / 2 - 1));
                if (y == 0 && i == 0) check("first_beat_err", frame_err, exp_err);
                if (y == H - 1 && i == W / 2 - 2) check("dr_before_last", data_ready, 0);
            end
        end
        check("mb_ready_pulse", MB_ready, 1);
        check("data_ready_up", data_ready, 1);
        check("pix_ready_ready", pix_ready, 0);
        @(posedge clk);
        #1;
        check("mb_ready_once", MB_ready, 0);
        check("data_ready_hold", data_ready, 1);
    endtask

    task automatic release_frame();
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        check("dr_after_done", data_ready, 0);
        check("pr_after_done", pix_ready, 1);
    endtask

    initial begin
        reset      = 1'b1;
        pix_data   = '0;
        pix_valid  = 1'b0;
        pix_sof    = 1'b0;
        pix_eol    = 1'b0;
        inq_addr   = '0;
        inq_update = 1'b0;
        frame_done = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pix_ready", pix_ready, 0);
        @(posedge clk);
        #1;
        check("rst_data_ready", data_ready, 0);
        check("rst_mb_ready", MB_ready, 0);
        check("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        #1;
        check("post_rst_pix_ready", pix_ready, 1);

        // 1: full frame
        send_frame(8'h00, 1'b0);
        rd("s1_addr5", 5, 1'b1, 32'h33322322);
        rd("s1_addr0", 0, 1'b1, 32'h11100100);
        rd("s1_addr7", 7, 1'b1, 32'h37362726);
        rd("s1_oob", 8, 1'b1, 32'h0);

        // 2: release and second frame
        release_frame();
        send_frame(8'h80, 1'b0);
        rd("s2_addr5", 5, 1'b1, 32'hB3B2A3A2);
        rd("s2_addr2", 2, 1'b1, 32'h95948584);
        release_frame();

        // 3: early eol on pair 2 of row 0
        beat(0, 0, 8'h00, 1'b1, 1'b0);
        beat(1, 0, 8'h00, 1'b0, 1'b0);
        check("s3_no_err_yet", frame_err, 0);
        beat(2, 0, 8'h00, 1'b0, 1'b1);
        check("s3_err_pulse", frame_err, 1);
        for (int k = 0; k < 5; k++) begin
            check("s3_drop_ready", pix_ready, 1);
            beat(k % 4, 1, 8'h00, 1'b0, (k % 4 == 3));
        end
        check("s3_err_cleared", frame_err, 0);
        check("s3_data_ready", data_ready, 0);

        // 4: sof re-asserted on beat 7
        for (int k = 0; k < 6; k++) begin
            beat(k % 4, k / 4, 8'h40, (k == 0), (k % 4 == 3));
        end
        check("s4_no_err_before", frame_err, 0);
        send_frame(8'h60, 1'b1);
        rd("s4_addr0", 0, 1'b1, 32'h71706160);
        rd("s4_addr7", 7, 1'b1, 32'h97968786);
        release_frame();

        // 5: reset mid-fill
        for (int k = 0; k < 10; k++) begin
            beat(k % 4, k / 4, 8'h20, (k == 0), (k % 4 == 3));
        end
        reset = 1'b1;
        #1;
        check("s5_rst_pix_ready", pix_ready, 0);
        @(posedge clk);
        #1;
        check("s5_rst_data_ready", data_ready, 0);
        check("s5_rst_mb_ready", MB_ready, 0);
        check("s5_rst_frame_err", frame_err, 0);
        reset = 1'b0;
        #1;
        check("s5_pix_ready", pix_ready, 1);
        send_frame(8'h00, 1'b0);
        rd("s5_addr5", 5, 1'b1, 32'h33322322);
        rd("s5_addr0", 0, 1'b1, 32'h11100100);

        // 6: READY ignores stream; reads gated by inq_update
        rd("s6_no_update", 0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            pix_data  = 16'hFFFF;
            pix_valid = 1'b1;
            pix_sof   = (k == 0);
            pix_eol   = 1'b1;
            #1;
            check("s6_pix_ready", pix_ready, 0);
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eol   = 1'b0;
        check("s6_data_ready", data_ready, 1);
        check("s6_no_err", frame_err, 0);
        rd("s6_addr0", 0, 1'b1, 32'h11100100);
        rd("s6_addr6", 6, 1'b1, 32'h35342524);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
